// File: rtl/md_ctrl_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// md_ctrl_pkg : md_op encodings, FSM state codes and decode helpers.  Rev 1.0
// ----------------------------------------------------------------------------
package md_ctrl_pkg;

  typedef enum logic [2:0] {
    MD_NONE  = 3'b000,
    MD_MULT  = 3'b001,
    MD_MULTU = 3'b010,
    MD_DIV   = 3'b011,
    MD_DIVU  = 3'b100,
    MD_MTHI  = 3'b101,
    MD_MTLO  = 3'b110
  } md_op_e;

  localparam logic [0:0] c_st_idle = 1'b0;
  localparam logic [0:0] c_st_busy = 1'b1;

  function automatic logic md_is_start(input logic [2:0] op);
    return op inside {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU};
  endfunction

  function automatic logic md_is_mult(input logic [2:0] op);
    return op inside {MD_MULT, MD_MULTU};
  endfunction

endpackage
`default_nettype wire

// File: rtl/md_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// md_ctrl : HI/LO mult/div sequencer with busy countdown and D-stage stall.  Rev 1.0
// ----------------------------------------------------------------------------
module md_ctrl
  import md_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  md_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        md_instr_D,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        md_stall
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;

  localparam logic [CNT_W-1:0] c_mult_load = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] c_div_load  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] c_cnt_one   = CNT_W'(1);

  logic [0:0]       r_state;
  logic [0:0]       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_hi;
  logic [31:0]      r_lo;
  logic [31:0]      r_p_hi;
  logic [31:0]      r_p_lo;
  logic [31:0]      w_res_hi;
  logic [31:0]      w_res_lo;
  logic             w_start;
  logic             w_last;

  assign w_start = (r_state == c_st_idle) && md_is_start(md_op);
  assign w_last  = (r_state == c_st_busy) && (r_cnt == c_cnt_one);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle: if (w_start) w_state_nxt = c_st_busy;
      c_st_busy: if (w_last)  w_state_nxt = c_st_idle;
      default:                w_state_nxt = c_st_idle;
    endcase
  end

  always_comb begin
    busy     = (r_state == c_st_busy);
    md_stall = md_instr_D && ((r_state == c_st_busy) || md_is_start(md_op));
  end

  // Divide by zero keeps the current HI/LO as the pending result, so the
  // eventual commit is a no-op; the signed overflow case is pinned explicitly.
  always_comb begin
    w_res_hi = r_hi;
    w_res_lo = r_lo;
    case (md_op)
      MD_MULT:  {w_res_hi, w_res_lo} = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
      MD_MULTU: {w_res_hi, w_res_lo} = {32'd0, a} * {32'd0, b};
      MD_DIV: begin
        if (b != 32'd0) begin
          if ((a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) begin
            w_res_lo = 32'h8000_0000;
            w_res_hi = 32'd0;
          end else begin
            w_res_lo = $signed(a) / $signed(b);
            w_res_hi = $signed(a) % $signed(b);
          end
        end
      end
      MD_DIVU: begin
        if (b != 32'd0) begin
          w_res_lo = a / b;
          w_res_hi = a % b;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt  <= '0;
      r_hi   <= '0;
      r_lo   <= '0;
      r_p_hi <= '0;
      r_p_lo <= '0;
    end else if (w_start) begin
      r_cnt  <= md_is_mult(md_op) ? c_mult_load : c_div_load;
      r_p_hi <= w_res_hi;
      r_p_lo <= w_res_lo;
    end else if (r_state == c_st_busy) begin
      r_cnt <= r_cnt - c_cnt_one;
      if (w_last) begin
        r_hi <= r_p_hi;
        r_lo <= r_p_lo;
      end
    end else begin
      if (md_op == MD_MTHI) r_hi <= a;
      if (md_op == MD_MTLO) r_lo <= a;
    end
  end

  assign hi = r_hi;
  assign lo = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_md_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_md_ctrl : directed bench with a cycle-indexed HI/LO/busy reference model.  Rev 1.0
// ----------------------------------------------------------------------------
module tb_md_ctrl;
  import md_ctrl_pkg::*;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [2:0]  md_op = MD_NONE;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        md_instr_D = 1'b0;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        md_stall;

  md_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) u_dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .md_op      (md_op),
    .a          (a),
    .b          (b),
    .md_instr_D (md_instr_D),
    .busy       (busy),
    .hi         (hi),
    .lo         (lo),
    .md_stall   (md_stall)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  // Reference model: an operation started in cycle c is busy in cycles
  // c+1..c+N and its result is visible from cycle c+N+1 on.
  int          cyc   = 0;
  int          m_end = -1;
  logic [31:0] m_hi  = '0;
  logic [31:0] m_lo  = '0;
  logic [31:0] m_phi = '0;
  logic [31:0] m_plo = '0;
  longint      sa, sb, res;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_end = -1;
      m_hi  = '0;
      m_lo  = '0;
      m_phi = '0;
      m_plo = '0;
    end else begin
      if (cyc == m_end) begin
        m_hi = m_phi;
        m_lo = m_plo;
      end else if (cyc > m_end) begin
        case (md_op)
          MD_MULT, MD_MULTU: begin
            if (md_op == MD_MULT) begin
              sa = longint'($signed(a));
              sb = longint'($signed(b));
            end else begin
              sa = longint'(a);
              sb = longint'(b);
            end
            res   = sa * sb;
            m_phi = res[63:32];
            m_plo = res[31:0];
            m_end = cyc + MC;
          end
          MD_DIV, MD_DIVU: begin
            if (b == 32'd0) begin
              m_phi = m_hi;
              m_plo = m_lo;
            end else begin
              if (md_op == MD_DIV) begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
              end else begin
                sa = longint'(a);
                sb = longint'(b);
              end
              res   = sa / sb;
              m_plo = res[31:0];
              res   = sa % sb;
              m_phi = res[31:0];
            end
            m_end = cyc + DC;
          end
          MD_MTHI: m_hi = a;
          MD_MTLO: m_lo = a;
          default: ;
        endcase
      end
      cyc++;
    end
  end

  bit   cmp_en = 1'b0;
  logic m_busy_e;
  logic m_stall_e;

  always @(negedge clk) begin
    if (cmp_en) begin
      m_busy_e  = (cyc <= m_end);
      m_stall_e = md_instr_D &&
                  (m_busy_e || (md_op inside {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU}));
      chk("cyc busy",  {31'd0, busy},     {31'd0, m_busy_e});
      chk("cyc hi",    hi,                m_hi);
      chk("cyc lo",    lo,                m_lo);
      chk("cyc stall", {31'd0, md_stall}, {31'd0, m_stall_e});
    end
  end

  task automatic issue(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
    #1;
    md_op = op;
    a     = x;
    b     = y;
    @(posedge clk);
    #1;
    md_op = MD_NONE;
  endtask

  // Counts busy cycles (and stalled ones) until the first idle cycle.
  task automatic count_busy(output int n, output int ns);
    n  = 0;
    ns = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
      if (md_stall) ns++;
    end
  endtask

  int nb, ns;

  initial begin
    #1 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset hi",   hi, 32'd0);
    chk("reset lo",   lo, 32'd0);
    cmp_en  = 1'b1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // MULT -2*3 with a D-stage HI/LO user waiting
    md_instr_D = 1'b1;
    #1;
    md_op = MD_MULT; a = 32'hFFFF_FFFE; b = 32'd3;
    @(negedge clk);
    chk("stall cycle0", {31'd0, md_stall}, 32'd1);
    @(posedge clk);
    #1;
    md_op = MD_NONE;
    count_busy(nb, ns);
    chk("mult busy len",   nb, MC);
    chk("mult stall len",  ns, MC);
    chk("stall after",     {31'd0, md_stall}, 32'd0);
    chk("mult hi",         hi, 32'hFFFF_FFFF);
    chk("mult lo",         lo, 32'hFFFF_FFFA);
    md_instr_D = 1'b0;

    // DIVU 100/7
    issue(MD_DIVU, 32'd100, 32'd7);
    count_busy(nb, ns);
    chk("divu busy len",  nb, DC);
    chk("divu stall len", ns, 0);
    chk("divu lo",        lo, 32'd14);
    chk("divu hi",        hi, 32'd2);

    // DIV -7/2
    issue(MD_DIV, 32'hFFFF_FFF9, 32'd2);
    count_busy(nb, ns);
    chk("div lo", lo, 32'hFFFF_FFFD);
    chk("div hi", hi, 32'hFFFF_FFFF);

    // MTHI/MTLO preload, then divide by zero
    issue(MD_MTHI, 32'h11, 32'd0);
    chk("mthi hi", hi, 32'h11);
    issue(MD_MTLO, 32'h22, 32'd0);
    chk("mtlo lo", lo, 32'h22);
    issue(MD_DIV, 32'd5, 32'd0);
    count_busy(nb, ns);
    chk("div0 busy len", nb, DC);
    chk("div0 hi",       hi, 32'h11);
    chk("div0 lo",       lo, 32'h22);

    // Signed overflow
    issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    count_busy(nb, ns);
    chk("ovf lo", lo, 32'h8000_0000);
    chk("ovf hi", hi, 32'd0);

    // Commands while busy are ignored; back-to-back start in first idle cycle
    issue(MD_MULTU, 32'd3, 32'd5);
    issue(MD_MTLO,  32'hAB, 32'd0);
    issue(MD_MULTU, 32'd7, 32'd7);
    count_busy(nb, ns);
    chk("ignored busy rest", nb, MC - 2);
    chk("ignored lo",        lo, 32'd15);
    chk("ignored hi",        hi, 32'd0);
    issue(MD_MULTU, 32'h0001_0000, 32'h0001_0000);
    count_busy(nb, ns);
    chk("b2b busy len", nb, MC);
    chk("b2b hi",       hi, 32'd1);
    chk("b2b lo",       lo, 32'd0);

    // Unused encoding behaves as NONE
    issue(3'b111, 32'd55, 32'd66);
    chk("op7 busy", {31'd0, busy}, 32'd0);
    chk("op7 hi",   hi, 32'd1);
    chk("op7 lo",   lo, 32'd0);

    // Reset in cycle 3 of a DIV
    issue(MD_DIV, 32'd50, 32'd3);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("pre-reset busy", {31'd0, busy}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("async busy", {31'd0, busy}, 32'd0);
    chk("async hi",   hi, 32'd0);
    chk("async lo",   lo, 32'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    chk("post-reset busy", {31'd0, busy}, 32'd0);
    chk("post-reset hi",   hi, 32'd0);
    chk("post-reset lo",   lo, 32'd0);

    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not complete, checks so far %0d", n_chk);
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/md_ctrl.md
# md_ctrl

Multiply/divide sequencer for the E stage of the five-stage pipeline. It accepts mult/multu/div/divu/mthi/mtlo commands from E. It holds HI/LO and models the multi-cycle latency of the unit with a busy counter. It also raises the D-stage stall that keeps later HI/LO users from issuing while the unit is occupied. The hazard unit ORs `md_stall` into its existing stall.

## Interface
Parameters:
- MULT_CYCLES, 5: busy cycles for mult/multu.
- DIV_CYCLES, 10: busy cycles for div/divu.

Ports:
- clk  in  1  pipeline clock.
- reset_n  in  1  asynchronous, active-low reset.
- md_op  in  3  E-stage command, encodings from Head.v:
  - 000 NONE
  - 001 MULT
  - 010 MULTU
  - 011 DIV
  - 100 DIVU
  - 101 MTHI
  - 110 MTLO
  - others treated as NONE.
- a  in  32  rs operand, forwarded value from E.
- b  in  32  rt operand, forwarded value from E.
- md_instr_D  in  1  D-stage instruction is any of mult/multu/div/divu/mfhi/mflo/mthi/mtlo.
- busy  out  1  unit occupied.
- hi  out  32  HI register.
- lo  out  32  LO register.
- md_stall  out  1  stall request for D.

## Operation
- States:
  - IDLE: busy=0.
  - BUSY: busy=1, `cnt` counts down.
- IDLE with md_op ∈ {MULT, MULTU, DIV, DIVU}, on the clock edge:
  - Compute the result into pending registers `p_hi`/`p_lo`.
  - Load `cnt` with MULT_CYCLES or DIV_CYCLES.
  - Go to BUSY.
- Result rules:
  - MULT: {p_hi, p_lo} = $signed(a) * $signed(b), 64-bit.
  - MULTU: same, unsigned.
  - DIV: p_lo = quotient, p_hi = remainder. Signed, truncating toward zero; the remainder takes the sign of the dividend.
  - DIVU: same, unsigned.
  - b==0 on DIV/DIVU: p_hi = hi and p_lo = lo, so the commit leaves HI/LO unchanged. Busy still runs the full DIV_CYCLES.
  - DIV of 0x80000000 by 0xFFFFFFFF: lo=0x80000000, hi=0.
- BUSY, on each edge:
  - cnt = cnt-1.
  - When cnt==1 at the edge: hi/lo ← p_hi/p_lo, go to IDLE.
- MTHI/MTLO in IDLE: hi←a or lo←a at the next edge. No busy.
- Any md_op other than NONE while in BUSY is ignored; it must not restart, overwrite or extend. The pipeline guarantees this cannot happen via `md_stall`.
- md_stall = md_instr_D && (busy || md_op ∈ {MULT, MULTU, DIV, DIVU}). This is combinational, with no register on the path.
- Flush/bubble in E arrives as md_op=NONE. A started operation is never cancelled.

## Timing
- Reset (async, reset_n=0) sets state=IDLE, cnt=0, busy=0, hi=0, lo=0, p_hi=0, p_lo=0. md_stall then follows its inputs.
- Reset mid-operation: the operation is abandoned immediately. HI/LO go to 0 with no commit.
- Start sampled at edge E0:
  - busy=1 in cycles 1..N, where N is MULT_CYCLES or DIV_CYCLES.
  - HI/LO change at the edge closing cycle N and are visible in cycle N+1, when busy=0.
- md_stall is asserted in cycle 0 (the start is visible on md_op) and in cycles 1..N whenever md_instr_D=1.
- MTHI/MTLO: the value is visible on hi/lo one cycle after issue.
- Back-to-back: a new start is accepted in cycle N+1, the first cycle busy=0.

## Structure
- md_op encodings go into Head.v as `MD_NONE`…`MD_MTLO`. The D-stage decoder and ControllerE share them.
- This is a single module; no sub-module is warranted.
- Arithmetic uses `*`, `/` and `%` with explicit $signed casts. Width is 64 for products and 32 for quotient/remainder.
- Counter width: $clog2(max(MULT_CYCLES, DIV_CYCLES))+1.

## Test plan
- MULT, a=0xFFFFFFFE (-2), b=3:
  - busy high exactly 5 cycles.
  - Then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
  - Values unchanged during busy.
- DIVU, a=100, b=7:
  - busy 10 cycles.
  - Then lo=14, hi=2.
  - DIV with a=-7 (0xFFFFFFF9), b=2 gives lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- Divide by zero:
  - Preload hi=0x11, lo=0x22 via MTHI/MTLO, then DIV a=5, b=0.
  - busy for 10 cycles; hi=0x11 and lo=0x22 afterwards.
- Stall coverage:
  - Start MULT with md_instr_D=1 held.
  - md_stall=1 from cycle 0 through cycle 5, 0 in cycle 6.
  - With md_instr_D=0, md_stall stays 0 throughout.
- Ignored and back-to-back commands:
  - MTLO a=0xAB and MULTU issued while busy are both ignored; the first result commits unchanged.
  - MULTU issued in the first busy=0 cycle is accepted.
- Reset mid-operation:
  - Pull reset_n low in cycle 3 of a DIV.
  - busy, hi and lo go to 0 immediately, without waiting for a clock edge.
  - After release, no commit occurs.
